or32_prog_loader: RTL and testbench

//  Upstream feeder of the subsoc OR32 program port (or32_en_i, or32_prog_addr/data/en_i).

---
 rtl/or32_prog_loader.sv | 153 +++++++++++++++
 tb/tb_or32_prog_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/or32_prog_loader.sv
// Command-stream front end for the OR32 program port.
// Parses LOAD/RUN/HALT/CLR_ERR packets and writes checksummed words into OR32 RAM.
module or32_prog_loader #(
  parameter int SFIFO_DW = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SFIFO_DW-1:0] din_i,
  input  logic                din_valid_i,
  output logic                din_ready_o,
  output logic                or32_en_o,
  output logic [31:0]         prog_addr_o,
  output logic [31:0]         prog_data_o,
  output logic                prog_en_o,
  output logic                busy_o,
  output logic                load_done_o,
  output logic                err_o
);

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR_HI,
    S_ADDR_LO,
    S_COUNT,
    S_DATA_HI,
    S_DATA_LO,
    S_CSUM
  } state_t;

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                en_q, en_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                pen_q, pen_d;
  logic [31:0]         paddr_q, paddr_d;
  logic [31:0]         pdata_q, pdata_d;
  logic [31:0]         addr_q, addr_d;
  logic [SFIFO_DW-1:0] hi_q, hi_d;
  logic [15:0]         sum_q, sum_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic       take;
  logic [3:0] op;

  assign take = din_valid_i && ready_q;
  assign op   = din_i[SFIFO_DW-1 -: 4];

  always_comb begin
    state_d = state_q;
    ready_d = 1'b1;
    en_d    = en_q;
    err_d   = err_q;
    done_d  = 1'b0;
    pen_d   = 1'b0;
    paddr_d = paddr_q;
    pdata_d = pdata_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    if (take) begin
      unique case (state_q)
        S_CMD: begin
          unique case (1'b1)
            (op == 4'h1): begin
              state_d = S_ADDR_HI;
              en_d    = 1'b0;
              sum_d   = '0;
            end
            (op == 4'h2): if (!err_q) en_d = 1'b1;
            (op == 4'h3): en_d = 1'b0;
            (op == 4'h4): err_d = 1'b0;
            default: err_d = 1'b1;
          endcase
        end
        S_ADDR_HI: begin
          hi_d    = din_i;
          state_d = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          addr_d  = {hi_q, din_i[SFIFO_DW-1:2], 2'b00};
          state_d = S_COUNT;
        end
        S_COUNT: begin
          cnt_d   = din_i[CNT_W-1:0];
          state_d = (din_i[CNT_W-1:0] == '0) ? S_CSUM : S_DATA_HI;
        end
        S_DATA_HI: begin
          hi_d    = din_i;
          sum_d   = sum_q + din_i;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          sum_d   = sum_q + din_i;
          pen_d   = 1'b1;
          pdata_d = {hi_q, din_i};
          paddr_d = addr_q;
          addr_d  = addr_q + 32'd4;
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_q == CNT_W'(1)) ? S_CSUM : S_DATA_HI;
        end
        S_CSUM: begin
          done_d  = 1'b1;
          if (din_i != sum_q) err_d = 1'b1;
          state_d = S_CMD;
        end
        default: state_d = S_CMD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CMD;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      pen_q   <= 1'b0;
      paddr_q <= '0;
      pdata_q <= '0;
      addr_q  <= '0;
      hi_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pen_q   <= pen_d;
      paddr_q <= paddr_d;
      pdata_q <= pdata_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

  assign din_ready_o = ready_q;
  assign or32_en_o   = en_q;
  assign prog_addr_o = paddr_q;
  assign prog_data_o = pdata_q;
  assign prog_en_o   = pen_q;
  assign busy_o      = (state_q != S_CMD);
  assign load_done_o = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_or32_prog_loader.sv
// Bench for or32_prog_loader: packet-level reference model,
// directed packets then randomized command mix.
module tb_or32_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        or32_en;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        prog_en;
  logic        busy;
  logic        load_done;
  logic        err;

  or32_prog_loader #(.SFIFO_DW(16), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .din_i       (din),
    .din_valid_i (din_valid),
    .din_ready_o (din_ready),
    .or32_en_o   (or32_en),
    .prog_addr_o (prog_addr),
    .prog_data_o (prog_data),
    .prog_en_o   (prog_en),
    .busy_o      (busy),
    .load_done_o (load_done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [63:0] act_q[$];
  logic [63:0] exp_q[$];
  int          act_done = 0;
  int          exp_done = 0;
  bit          m_err = 0;
  bit          m_en = 0;
  logic [63:0] m_last = '0;
  logic [31:0] pd[16];
  bit          toggle = 0;
  int          gap_max = 0;

  always @(negedge clk) begin
    if (prog_en) act_q.push_back({prog_addr, prog_data});
    if (load_done) act_done++;
  end

  task automatic put(input logic [15:0] w);
    int g;
    g = toggle ? 1 : $urandom_range(0, gap_max);
    repeat (g) begin
      @(posedge clk);
      #1;
    end
    din = w;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din = 16'($urandom);
  endtask

  task automatic settle(input string tag);
    logic [63:0] a;
    logic [63:0] e;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, ".err"}, err, m_err);
    chk({tag, ".en"}, or32_en, m_en);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, 64'(act_done), 64'(exp_done));
    chk({tag, ".nwr"}, 64'(act_q.size()), 64'(exp_q.size()));
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, ".wr"}, a, e);
    end
    act_q.delete();
    exp_q.delete();
    chk({tag, ".hold"}, {prog_addr, prog_data}, m_last);
  endtask

  task automatic do_load(input string tag, input logic [31:0] a,
                         input int n, input bit bad);
    logic [15:0] s;
    logic [31:0] base;
    logic [15:0] c;
    s = '0;
    base = {a[31:2], 2'b00};
    put({4'h1, 12'($urandom)});
    chk({tag, ".en_drop"}, or32_en, 0);
    chk({tag, ".busy_on"}, busy, 1);
    m_en = 0;
    put(a[31:16]);
    put(a[15:0]);
    put(16'(n));
    for (int i = 0; i < n; i++) begin
      put(pd[i][31:16]);
      put(pd[i][15:0]);
      s = s + pd[i][31:16] + pd[i][15:0];
      m_last = {base + 32'(4 * i), pd[i]};
      exp_q.push_back(m_last);
    end
    c = bad ? s + 16'($urandom_range(1, 65535)) : s;
    put(c);
    if (bad) m_err = 1;
    exp_done++;
    settle(tag);
  endtask

  task automatic cmd(input string tag, input logic [3:0] op);
    put({op, 12'($urandom)});
    case (op)
      4'h2: if (!m_err) m_en = 1;
      4'h3: m_en = 0;
      4'h4: m_err = 0;
      default: m_err = 1;
    endcase
    settle(tag);
  endtask

  task automatic rand_data(input int n);
    for (int i = 0; i < n; i++) pd[i] = $urandom;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", din_ready, 0);
    chk("rst.outs", {or32_en, prog_addr, prog_data, prog_en, busy,
                     load_done, err}, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.ready_up", din_ready, 1);

    pd[0] = 32'h1111_2222;
    pd[1] = 32'h3333_4444;
    do_load("t1", 32'h0000_0100, 2, 0);
    do_load("t2", 32'h0000_0100, 2, 1);
    cmd("t2.run_blocked", 4'h2);
    cmd("t2.clr", 4'h4);
    cmd("t2.run", 4'h2);

    cmd("t3.run", 4'h2);
    do_load("t3", $urandom, 0, 0);

    cmd("t4.badop", 4'h7);
    rand_data(2);
    do_load("t4", 32'hFFFF_FFFC, 2, 0);
    cmd("t4.clr", 4'h4);

    gap_max = 2;
    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 5) begin
        int n;
        n = $urandom_range(0, 5);
        rand_data(n);
        do_load("rnd.load", $urandom, n, ($urandom_range(0, 4) == 0));
      end else if (sel == 5) cmd("rnd.run", 4'h2);
      else if (sel == 6) cmd("rnd.halt", 4'h3);
      else if (sel == 7) cmd("rnd.clr", 4'h4);
      else if (sel == 8) cmd("rnd.badop", 4'($urandom_range(5, 15)));
      else cmd("rnd.op0", 4'h0);
    end

    gap_max = 0;
    cmd("t5.clr", 4'h4);
    toggle = 1;
    rand_data(3);
    do_load("t5", $urandom, 3, 0);

    put({4'h1, 12'h000});
    put(16'h2000);
    put(16'h0040);
    put(16'd3);
    put(16'hABCD);
    toggle = 0;
    din = 16'h1234;
    din_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    chk("t5.rst.ready", din_ready, 0);
    chk("t5.rst.outs", {or32_en, prog_addr, prog_data, prog_en, busy,
                        load_done, err}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_err = 0;
    m_en = 0;
    m_last = '0;
    exp_q.delete();
    act_q.delete();
    act_done = 0;
    exp_done = 0;
    @(posedge clk);
    #1;
    chk("t5.rst.ready_up", din_ready, 1);
    cmd("t5.after_rst", 4'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
